edge_event_scheduler: RTL and testbench



---
 rtl/edge_pkg.sv | 7 +
 rtl/edge_event_cell.sv | 41 ++++
 rtl/edge_event_scheduler.sv | 70 +++++++
 tb/tb_edge_event_scheduler.sv | 127 ++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// edge_pkg: shared types and limits for the edge event scheduler family.
// Build option EDGE_SYNC_EN (used by edge_event_cell) inserts per-channel input synchronizers.
package edge_pkg;
    typedef enum logic {EDGE_FALL, EDGE_RISE} edge_t;
    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;
    localparam int N_CH_MAX = 16;
endpackage

// File: rtl/edge_event_cell.sv
// edge_event_cell: one channel's both-edge detector holding a single pending event plus overflow flag.
// Define EDGE_SYNC_EN to pass x through a 2-flop synchronizer ahead of prev/detect.
module edge_event_cell
    import edge_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  x,
    input  logic  mask,
    input  logic  clr,
    output logic  pend,
    output edge_t pol,
    output logic  ovf
);
    logic xs;
`ifdef EDGE_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk) sync_q <= rst ? 2'b00 : {sync_q[0], x};
    assign xs = sync_q[1];
`else
    assign xs = x;
`endif
    logic  prev_q, pend_q, pend_d, ovf_q, ovf_d, det;
    edge_t pol_q, pol_d;
    assign det = mask && (xs != prev_q);
    // A grant in the same cycle as a new edge clears first, so the new edge starts clean.
    always_comb begin
        pend_d = det || (pend_q && !clr);
        pol_d  = det ? edge_t'(xs) : pol_q;
        ovf_d  = det ? (pend_q && !clr) : (ovf_q && !clr);
    end
    always_ff @(posedge clk) begin
        prev_q <= xs;
        pend_q <= rst ? 1'b0 : pend_d;
        pol_q  <= rst ? EDGE_FALL : pol_d;
        ovf_q  <= rst ? 1'b0 : ovf_d;
    end
    assign pend = pend_q;
    assign pol  = pol_q;
    assign ovf  = ovf_q;
endmodule

// File: rtl/edge_event_scheduler.sv
// edge_event_scheduler: N_CH-channel edge detector with round-robin arbitration onto one valid/ready port.
// EDGE_SYNC_EN (in edge_event_cell) adds a 2-flop synchronizer per channel, +2 cycles latency.
module edge_event_scheduler
    import edge_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         x,
    input  logic [N_CH-1:0]         mask,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [$clog2(N_CH)-1:0] evt_ch,
    output logic                    evt_rise,
    output logic                    evt_ovf
);
    localparam int CH_W = $clog2(N_CH);
    logic [N_CH-1:0] pend, ovf, clr;
    edge_t           pol [N_CH];
    slot_state_t     state_q, state_d;
    logic [CH_W-1:0] rr_q, gnt, ch_q;
    edge_t           rise_q;
    logic            ovf_q, load;
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign clr[i] = load && (gnt == CH_W'(i));
        edge_event_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .x    (x[i]),
            .mask (mask[i]),
            .clr  (clr[i]),
            .pend (pend[i]),
            .pol  (pol[i]),
            .ovf  (ovf[i])
        );
    end
    // Scan downward so the last hit is the first pending channel after rr_q.
    always_comb begin
        gnt = rr_q;
        for (int k = N_CH; k >= 1; k--) begin
            logic [CH_W-1:0] j;
            j = CH_W'((int'(rr_q) + k) % N_CH);
            if (pend[j]) gnt = j;
        end
    end
    assign load    = (|pend) && (state_q == SLOT_EMPTY || evt_ready);
    assign state_d = load ? SLOT_FULL : (evt_ready ? SLOT_EMPTY : state_q);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            rr_q    <= CH_W'(N_CH - 1);
            ch_q    <= '0;
            rise_q  <= EDGE_FALL;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                rr_q   <= gnt;
                ch_q   <= gnt;
                rise_q <= pol[gnt];
                ovf_q  <= ovf[gnt];
            end
        end
    end
    assign evt_valid = (state_q == SLOT_FULL);
    assign evt_ch    = ch_q;
    assign evt_rise  = (rise_q == EDGE_RISE);
    assign evt_ovf   = ovf_q;
endmodule

// File: tb/tb_edge_event_scheduler.sv
// tb_edge_event_scheduler: directed stimulus with a queue scoreboard checked by an independent monitor.
module tb_edge_event_scheduler;
    logic       clk = 1'b0, rst = 1'b1, evt_ready = 1'b0;
    logic [3:0] x = 4'b0000, mask = 4'hF;
    logic       evt_valid, evt_rise, evt_ovf;
    logic [1:0] evt_ch;
    int n_cmp = 0, n_err = 0;
    typedef struct packed {logic [1:0] ch; logic rise; logic ovf;} ev_t;
    ev_t exp_q[$];
    ev_t exp_e;

    always #5 clk = ~clk;

    edge_event_scheduler #(.N_CH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .mask      (mask),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_rise  (evt_rise),
        .evt_ovf   (evt_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] c, input logic r, input logic o);
        exp_q.push_back(ev_t'{c, r, o});
    endtask

    // Monitor: every accepted event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL evt_unexpected: got ch=%0d rise=%0b ovf=%0b, expected no event", evt_ch, evt_rise, evt_ovf);
            end else begin
                exp_e = exp_q.pop_front();
                if ({evt_ch, evt_rise, evt_ovf} !== exp_e) begin
                    n_err++;
                    $display("FAIL evt_payload: got ch=%0d rise=%0b ovf=%0b, expected ch=%0d rise=%0b ovf=%0b",
                             evt_ch, evt_rise, evt_ovf, exp_e.ch, exp_e.rise, exp_e.ovf);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; x = 4'b1010; mask = 4'hF; evt_ready = 1'b1;
        tick(3);
        @(negedge clk);
        chk("rst_valid", evt_valid, 0);
        chk("rst_ch", evt_ch, 0);
        chk("rst_rise", evt_rise, 0);
        chk("rst_ovf", evt_ovf, 0);
        tick(1); rst = 1'b0;
        repeat (10) begin @(negedge clk); chk("idle_after_rst", evt_valid, 0); end
        // single rising edge on channel 2: valid two edges later for one cycle
        tick(1); x = 4'b1110; push(2'd2, 1'b1, 1'b0);
        @(negedge clk); @(negedge clk); chk("lat_edge_k", evt_valid, 0);
        @(negedge clk); chk("lat_edge_k1", evt_valid, 1);
        @(negedge clk); chk("lat_one_cycle", evt_valid, 0);
        // falls on 1,2,3 with rr_ptr at 2: order 3,1,2
        tick(1); x = 4'b0000; push(2'd3, 1'b0, 1'b0); push(2'd1, 1'b0, 1'b0); push(2'd2, 1'b0, 1'b0);
        tick(6);
        rst = 1'b1; tick(2); rst = 1'b0; tick(2);
        // all rise at once: four back-to-back events 0..3
        x = 4'b1111;
        for (int c = 0; c < 4; c++) push(2'(c), 1'b1, 1'b0);
        @(negedge clk); @(negedge clk);
        repeat (4) begin @(negedge clk); chk("b2b_valid", evt_valid, 1); end
        @(negedge clk); chk("b2b_drain", evt_valid, 0);
        tick(1); x = 4'b0000;
        for (int c = 0; c < 4; c++) push(2'(c), 1'b0, 1'b0);
        tick(8);
        // stall: slot holds ch0 while ch1 pulses and overflows
        evt_ready = 1'b0; x = 4'b0001; push(2'd0, 1'b1, 1'b0);
        tick(4);
        x = 4'b0011; tick(1); x = 4'b0001; push(2'd1, 1'b0, 1'b1);
        repeat (4) begin
            @(negedge clk);
            chk("stall_valid", evt_valid, 1);
            chk("stall_ch", evt_ch, 0);
            chk("stall_rise", evt_rise, 1);
        end
        tick(1); evt_ready = 1'b1; tick(4);
        // masked channel 3 produces nothing, even once unmasked with steady input
        mask = 4'b0111; x = 4'b1001; tick(2); x = 4'b0001; tick(1);
        repeat (4) begin @(negedge clk); chk("masked_no_evt", evt_valid, 0); end
        tick(1); mask = 4'hF;
        repeat (4) begin @(negedge clk); chk("unmask_steady", evt_valid, 0); end
        tick(1); x = 4'b1001; push(2'd3, 1'b1, 1'b0);
        tick(4);
        // ch0 toggles every cycle, ch3 falls once; ch3 must win the second grant
        push(2'd0, 1'b0, 1'b0); push(2'd3, 1'b0, 1'b0); push(2'd0, 1'b0, 1'b1);
        x = 4'b0000; tick(1);
        x = 4'b0001; tick(1);
        x = 4'b0000; tick(1);
        x = 4'b0001; tick(1);
        rst = 1'b1;
        @(negedge clk); @(negedge clk); chk("rst_drop_valid", evt_valid, 0);
        tick(1); rst = 1'b0;
        repeat (6) begin @(negedge clk); chk("post_rst_idle", evt_valid, 0); end
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
